mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_in (rising edge), rst_in.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
  clk_in  in  1  clock
  rst_in  in  1  sync active-high reset
  rdy_in  in  1  global enable; low = freeze all state
  clr_in  in  1  pipeline flush (mispredict)
  io_buffer_full  in  1  UART output buffer full
  if_to_arb_req  in  1  fetch request, level, held until done
  if_to_arb_addr  in  32  fetch address
  arb_to_if_done  out  1  one-cycle fetch-complete pulse
  arb_to_if_inst  out  32  fetched word, valid with done
  lsb_to_arb_req  in  1  LSB request, level, held until done
  lsb_to_arb_wr  in  1  1 = store, 0 = load
  lsb_to_arb_len  in  3  byte count: 1, 2 or 4
  lsb_to_arb_addr  in  32  LSB address
  lsb_to_arb_wdata  in  32  store data
  arb_to_lsb_done  out  1  one-cycle LSB-complete pulse
  arb_to_lsb_rdata  out  32  load result, valid with done
  arb_to_mc_valid  out  1  downstream request, held until mc done
  arb_to_mc_wr  out  1  downstream direction
  arb_to_mc_len  out  3  downstream byte count (IF always 4)
  arb_to_mc_addr  out  32  downstream address
  arb_to_mc_data  out  32  downstream store data
  mc_to_arb_done  in  1  downstream one-cycle completion pulse
  mc_to_arb_rdata  in  32  downstream read data, valid with done
REQ-003 Parameter: STARVE_LIMIT, default 4, max consecutive LSB grants while a fetch waits.

Function
REQ-004 States SHALL be IDLE, BUSY_IF, BUSY_LSB, RESP.
REQ-005 In IDLE, arbitration each cycle: LSB wins if lsb_to_arb_req and not blocked (REQ-006) and starve_cnt < STARVE_LIMIT; else IF wins if if_to_arb_req and clr_in low; else remain IDLE.
REQ-006 An LSB store SHALL be blocked while io_buffer_full=1 and addr is 0x30000 or 0x30004; a blocked store does not prevent an IF grant that cycle.
REQ-007 On grant, next cycle: arb_to_mc_valid=1 with addr/len/wr/data latched from the winner; IF grants drive len=4, wr=0, data=0.
REQ-008 Downstream fields SHALL stay stable while arb_to_mc_valid=1; valid drops in the cycle after mc_to_arb_done is sampled.
REQ-009 starve_cnt (3 bits, saturating): +1 on each LSB grant while if_to_arb_req=1; cleared on any IF grant or when if_to_arb_req=0 in IDLE.
REQ-010 On mc_to_arb_done in BUSY_x: capture mc_to_arb_rdata, go to RESP; in RESP pulse the matching done output for exactly one cycle with data, then return to IDLE; a new grant is possible no earlier than the RESP cycle + 1 (one idle bubble minimum).
REQ-011 Loads of len 1/2: rdata passed unmodified (downstream zero-extends); stores return rdata=0.
REQ-012 clr_in in BUSY_IF SHALL set a discard flag; the transaction drains downstream, arb_to_if_done is suppressed and discard clears on return to IDLE.
REQ-013 clr_in in RESP for an IF transaction SHALL suppress that arb_to_if_done pulse.
REQ-014 clr_in SHALL NOT affect LSB transactions or starve_cnt.
REQ-015 If if_to_arb_req and lsb_to_arb_req drop while BUSY, the transaction still completes; done still pulses (requester ignores).
REQ-016 rdy_in=0: all registers hold; done pulses are extended until rdy_in returns.
REQ-017 mc_to_arb_done outside BUSY_x SHALL be ignored.

Reset
REQ-018 rst_in=1 at a clock edge: state IDLE, starve_cnt=0, discard=0, all outputs 0, including mid-transaction (downstream abort is the mc's own reset responsibility).
REQ-019 Reset SHALL take priority over rdy_in and clr_in.

Verification
REQ-020 Both req in same IDLE cycle, LSB load addr 0x1000 len 4 -> mc_valid next cycle with addr 0x1000; IF granted only after LSB done + RESP.
REQ-021 LSB requests back-to-back 5 times with IF pending, STARVE_LIMIT=4 -> 5th grant goes to IF at if_addr.
REQ-022 io_buffer_full=1, store to 0x30000 plus fetch 0x200 -> IF granted; store granted after io_buffer_full drops.
REQ-023 clr_in pulsed 2 cycles after IF grant, mc returns 0xDEADBEEF -> no arb_to_if_done; state IDLE after drain.
REQ-024 Load len 1, mc rdata 0x000000A5 -> arb_to_lsb_done for one cycle with rdata 0x000000A5; rdy_in low during RESP stretches pulse.
REQ-025 rst_in asserted in BUSY_LSB -> next cycle all outputs 0, state IDLE; new request granted normally afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates the instruction-fetch unit (IF) and the load/store
//            buffer (LSB) onto one downstream memory-controller port. LSB
//            wins by default, but a waiting fetch is served after at most
//            STARVE_LIMIT consecutive LSB grants. Stores to the UART data and
//            status words are held back while the UART buffer is full.
// Ports    : clk_in / rst_in      clock, synchronous active-high reset
//            rdy_in               global enable (low freezes all state)
//            clr_in               pipeline flush, discards an in-flight fetch
//            io_buffer_full       UART output buffer full
//            if_to_arb_*          fetch request (level) and address
//            arb_to_if_*          fetch-complete pulse and fetched word
//            lsb_to_arb_*         load/store request, direction, size, data
//            arb_to_lsb_*         LSB-complete pulse and load data
//            arb_to_mc_*          downstream request, held until mc done
//            mc_to_arb_*          downstream completion pulse and read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4  // meaningful range 1..7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        io_buffer_full,
  input  logic        if_to_arb_req,
  input  logic [31:0] if_to_arb_addr,
  output logic        arb_to_if_done,
  output logic [31:0] arb_to_if_inst,
  input  logic        lsb_to_arb_req,
  input  logic        lsb_to_arb_wr,
  input  logic [2:0]  lsb_to_arb_len,
  input  logic [31:0] lsb_to_arb_addr,
  input  logic [31:0] lsb_to_arb_wdata,
  output logic        arb_to_lsb_done,
  output logic [31:0] arb_to_lsb_rdata,
  output logic        arb_to_mc_valid,
  output logic        arb_to_mc_wr,
  output logic [2:0]  arb_to_mc_len,
  output logic [31:0] arb_to_mc_addr,
  output logic [31:0] arb_to_mc_data,
  input  logic        mc_to_arb_done,
  input  logic [31:0] mc_to_arb_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_LSB = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [2:0]  C_STARVE_LIMIT = 3'(STARVE_LIMIT);
  localparam logic [2:0]  C_STARVE_MAX   = 3'd7;
  localparam logic [31:0] C_UART_DATA    = 32'h0003_0000;
  localparam logic [31:0] C_UART_STAT    = 32'h0003_0004;

  state_t      state_q, state_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic        discard_q, discard_d;
  logic        txn_if_q, txn_if_d;     // owner of the current transaction
  logic [31:0] rdata_q, rdata_d;
  logic        mc_wr_q, mc_wr_d;
  logic [2:0]  mc_len_q, mc_len_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_data_q, mc_data_d;

  logic        w_lsb_blocked;
  logic        w_lsb_win;
  logic        w_if_win;
  logic [2:0]  w_starve_inc;

  // Arbitration terms. A blocked UART store simply drops out of the race,
  // so a pending fetch can still be granted in the same cycle.
  always_comb begin
    w_lsb_blocked = lsb_to_arb_wr && io_buffer_full &&
                    ((lsb_to_arb_addr == C_UART_DATA) ||
                     (lsb_to_arb_addr == C_UART_STAT));
    w_lsb_win     = lsb_to_arb_req && !w_lsb_blocked &&
                    (starve_cnt_q < C_STARVE_LIMIT);
    w_if_win      = !w_lsb_win && if_to_arb_req && !clr_in;
    w_starve_inc  = (starve_cnt_q == C_STARVE_MAX) ? C_STARVE_MAX
                                                   : starve_cnt_q + 3'd1;
  end

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    discard_d    = discard_q;
    txn_if_d     = txn_if_q;
    rdata_d      = rdata_q;
    mc_wr_d      = mc_wr_q;
    mc_len_d     = mc_len_q;
    mc_addr_d    = mc_addr_q;
    mc_data_d    = mc_data_q;

    case (state_q)
      IDLE: begin
        if (w_lsb_win) begin
          state_d      = BUSY_LSB;
          txn_if_d     = 1'b0;
          mc_wr_d      = lsb_to_arb_wr;
          mc_len_d     = lsb_to_arb_len;
          mc_addr_d    = lsb_to_arb_addr;
          mc_data_d    = lsb_to_arb_wdata;
          // Only grants taken while a fetch is waiting count as starvation.
          starve_cnt_d = if_to_arb_req ? w_starve_inc : 3'd0;
        end else if (w_if_win) begin
          state_d      = BUSY_IF;
          txn_if_d     = 1'b1;
          mc_wr_d      = 1'b0;
          mc_len_d     = 3'd4;
          mc_addr_d    = if_to_arb_addr;
          mc_data_d    = 32'd0;
          starve_cnt_d = 3'd0;
        end else if (!if_to_arb_req) begin
          starve_cnt_d = 3'd0;
        end
      end

      BUSY_IF, BUSY_LSB: begin
        // A flushed fetch still drains downstream; only its reply is dropped.
        if ((state_q == BUSY_IF) && clr_in) begin
          discard_d = 1'b1;
        end
        if (mc_to_arb_done) begin
          state_d   = RESP;
          rdata_d   = ((state_q == BUSY_LSB) && mc_wr_q) ? 32'd0
                                                         : mc_to_arb_rdata;
          mc_wr_d   = 1'b0;
          mc_len_d  = 3'd0;
          mc_addr_d = 32'd0;
          mc_data_d = 32'd0;
        end
      end

      RESP: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset overrides the freeze; rdy_in low holds every register, which is
  // also what stretches a done pulse sitting in RESP.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      starve_cnt_q <= 3'd0;
      discard_q    <= 1'b0;
      txn_if_q     <= 1'b0;
      rdata_q      <= 32'd0;
      mc_wr_q      <= 1'b0;
      mc_len_q     <= 3'd0;
      mc_addr_q    <= 32'd0;
      mc_data_q    <= 32'd0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      discard_q    <= discard_d;
      txn_if_q     <= txn_if_d;
      rdata_q      <= rdata_d;
      mc_wr_q      <= mc_wr_d;
      mc_len_q     <= mc_len_d;
      mc_addr_q    <= mc_addr_d;
      mc_data_q    <= mc_data_d;
    end
  end

  // A flush arriving during the response cycle itself must still be able to
  // kill the fetch reply, hence the direct clr_in term.
  always_comb begin
    arb_to_mc_valid  = (state_q == BUSY_IF) || (state_q == BUSY_LSB);
    arb_to_mc_wr     = mc_wr_q;
    arb_to_mc_len    = mc_len_q;
    arb_to_mc_addr   = mc_addr_q;
    arb_to_mc_data   = mc_data_q;
    arb_to_if_done   = (state_q == RESP) && txn_if_q && !discard_q && !clr_in;
    arb_to_lsb_done  = (state_q == RESP) && !txn_if_q;
    arb_to_if_inst   = arb_to_if_done  ? rdata_q : 32'd0;
    arb_to_lsb_rdata = arb_to_lsb_done ? rdata_q : 32'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//            predicts, for every cycle, the downstream request and the done
//            pulses; directed scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in, io_buffer_full;
  logic        if_to_arb_req;
  logic [31:0] if_to_arb_addr;
  logic        lsb_to_arb_req, lsb_to_arb_wr;
  logic [2:0]  lsb_to_arb_len;
  logic [31:0] lsb_to_arb_addr, lsb_to_arb_wdata;
  logic        mc_to_arb_done;
  logic [31:0] mc_to_arb_rdata;
  logic        arb_to_if_done, arb_to_lsb_done;
  logic [31:0] arb_to_if_inst, arb_to_lsb_rdata;
  logic        arb_to_mc_valid, arb_to_mc_wr;
  logic [2:0]  arb_to_mc_len;
  logic [31:0] arb_to_mc_addr, arb_to_mc_data;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clr_in           (clr_in),
    .io_buffer_full   (io_buffer_full),
    .if_to_arb_req    (if_to_arb_req),
    .if_to_arb_addr   (if_to_arb_addr),
    .arb_to_if_done   (arb_to_if_done),
    .arb_to_if_inst   (arb_to_if_inst),
    .lsb_to_arb_req   (lsb_to_arb_req),
    .lsb_to_arb_wr    (lsb_to_arb_wr),
    .lsb_to_arb_len   (lsb_to_arb_len),
    .lsb_to_arb_addr  (lsb_to_arb_addr),
    .lsb_to_arb_wdata (lsb_to_arb_wdata),
    .arb_to_lsb_done  (arb_to_lsb_done),
    .arb_to_lsb_rdata (arb_to_lsb_rdata),
    .arb_to_mc_valid  (arb_to_mc_valid),
    .arb_to_mc_wr     (arb_to_mc_wr),
    .arb_to_mc_len    (arb_to_mc_len),
    .arb_to_mc_addr   (arb_to_mc_addr),
    .arb_to_mc_data   (arb_to_mc_data),
    .mc_to_arb_done   (mc_to_arb_done),
    .mc_to_arb_rdata  (mc_to_arb_rdata)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one outstanding transaction record plus the starvation
  // count. "active" = a transaction owns the port, "replied" = mc has answered
  // and the requester is being told this cycle.
  // --------------------------------------------------------------------------
  bit          m_active, m_replied, m_is_if, m_wr, m_discard;
  logic [2:0]  m_len;
  logic [31:0] m_addr, m_data, m_rdata;
  int          m_starve;

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    bit blk;
    if (rst_in) begin
      m_active = 0; m_replied = 0; m_discard = 0; m_starve = 0;
    end else if (rdy_in) begin
      if (m_active && !m_replied) begin
        if (m_is_if && clr_in) m_discard = 1;
        if (mc_to_arb_done) begin
          m_replied = 1;
          m_rdata   = (!m_is_if && m_wr) ? 32'd0 : mc_to_arb_rdata;
        end
      end else if (m_active) begin
        m_active = 0; m_replied = 0; m_discard = 0;
      end else begin
        blk = lsb_to_arb_wr && io_buffer_full &&
              (lsb_to_arb_addr == 32'h30000 || lsb_to_arb_addr == 32'h30004);
        if (lsb_to_arb_req && !blk && m_starve < STARVE_LIMIT) begin
          m_active = 1; m_is_if = 0;
          m_addr = lsb_to_arb_addr; m_len = lsb_to_arb_len;
          m_wr = lsb_to_arb_wr; m_data = lsb_to_arb_wdata;
          m_starve = if_to_arb_req ? ((m_starve < 7) ? m_starve + 1 : 7) : 0;
        end else if (if_to_arb_req && !clr_in) begin
          m_active = 1; m_is_if = 1;
          m_addr = if_to_arb_addr; m_len = 3'd4; m_wr = 0; m_data = 32'd0;
          m_starve = 0;
        end else if (!if_to_arb_req) begin
          m_starve = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit ev, eif, elsb;
    ev   = m_active && !m_replied;
    eif  = m_active && m_replied && m_is_if && !m_discard && !clr_in;
    elsb = m_active && m_replied && !m_is_if;
    check_eq("mc_valid", 32'(arb_to_mc_valid), 32'(ev));
    if (ev) begin
      check_eq("mc_addr", arb_to_mc_addr, m_addr);
      check_eq("mc_len",  32'(arb_to_mc_len), 32'(m_len));
      check_eq("mc_wr",   32'(arb_to_mc_wr), 32'(m_wr));
      check_eq("mc_data", arb_to_mc_data, m_data);
    end
    check_eq("if_done",  32'(arb_to_if_done), 32'(eif));
    if (eif) check_eq("if_inst", arb_to_if_inst, m_rdata);
    check_eq("lsb_done", 32'(arb_to_lsb_done), 32'(elsb));
    if (elsb) check_eq("lsb_rdata", arb_to_lsb_rdata, m_rdata);
  endtask

  // Inputs are changed at the falling edge, then one clock is run and the
  // outputs are checked at the following falling edge.
  task automatic tick();
    model_step();
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic mc_reply(input logic [31:0] d);
    mc_to_arb_done = 1'b1; mc_to_arb_rdata = d;
    tick();
    mc_to_arb_done = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!arb_to_mc_valid && n < 20);
    check_eq({tag, "_grant"}, 32'(arb_to_mc_valid), 32'd1);
  endtask

  task automatic set_lsb(input logic wr, input logic [2:0] len,
                         input logic [31:0] addr, input logic [31:0] wd);
    lsb_to_arb_req = 1'b1; lsb_to_arb_wr = wr; lsb_to_arb_len = len;
    lsb_to_arb_addr = addr; lsb_to_arb_wdata = wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst_in = 1; rdy_in = 1; clr_in = 0; io_buffer_full = 0;
    if_to_arb_req = 0; if_to_arb_addr = 0;
    lsb_to_arb_req = 0; lsb_to_arb_wr = 0; lsb_to_arb_len = 0;
    lsb_to_arb_addr = 0; lsb_to_arb_wdata = 0;
    mc_to_arb_done = 0; mc_to_arb_rdata = 0;
    m_active = 0; m_replied = 0; m_discard = 0; m_starve = 0;
    m_is_if = 0; m_wr = 0; m_len = 0; m_addr = 0; m_data = 0; m_rdata = 0;

    tick(); tick();
    check_eq("rst_valid",  32'(arb_to_mc_valid), 32'd0);
    check_eq("rst_addr",   arb_to_mc_addr, 32'd0);
    check_eq("rst_ifdone", 32'(arb_to_if_done), 32'd0);
    rst_in = 0;
    tick();

    // Simultaneous requests: LSB first, IF only after LSB done + bubble.
    set_lsb(1'b0, 3'd4, 32'h1000, 32'd0);
    if_to_arb_req = 1; if_to_arb_addr = 32'h40;
    tick();
    check_eq("both_valid", 32'(arb_to_mc_valid), 32'd1);
    check_eq("both_addr",  arb_to_mc_addr, 32'h1000);
    tick();
    mc_reply(32'h1111_2222);
    check_eq("both_lsbdone", 32'(arb_to_lsb_done), 32'd1);
    check_eq("both_lsbdata", arb_to_lsb_rdata, 32'h1111_2222);
    lsb_to_arb_req = 0;
    tick();
    check_eq("both_bubble", 32'(arb_to_mc_valid), 32'd0);
    tick();
    check_eq("both_ifaddr", arb_to_mc_addr, 32'h40);
    check_eq("both_iflen",  32'(arb_to_mc_len), 32'd4);
    mc_reply(32'h0badf00d);
    check_eq("both_ifinst", arb_to_if_inst, 32'h0badf00d);
    if_to_arb_req = 0;
    tick();

    // Starvation bound: the fifth grant goes to the waiting fetch.
    if_to_arb_req = 1; if_to_arb_addr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      set_lsb(1'b0, 3'd4, 32'h2000 + 32'(i * 4), 32'd0);
      wait_grant("starve");
      check_eq("starve_addr", arb_to_mc_addr, (i < 4) ? 32'h2000 + 32'(i * 4) : 32'h80);
      mc_reply(32'(i));
    end
    if_to_arb_req = 0; lsb_to_arb_req = 0;
    tick();

    // UART-blocked store lets the fetch through, then goes when unblocked.
    io_buffer_full = 1;
    set_lsb(1'b1, 3'd1, 32'h30000, 32'h41);
    if_to_arb_req = 1; if_to_arb_addr = 32'h200;
    wait_grant("uart_if");
    check_eq("uart_ifaddr", arb_to_mc_addr, 32'h200);
    check_eq("uart_ifwr",   32'(arb_to_mc_wr), 32'd0);
    mc_reply(32'h13);
    if_to_arb_req = 0;
    tick(); tick(); tick();
    check_eq("uart_held", 32'(arb_to_mc_valid), 32'd0);
    io_buffer_full = 0;
    wait_grant("uart_st");
    check_eq("uart_staddr", arb_to_mc_addr, 32'h30000);
    check_eq("uart_stdata", arb_to_mc_data, 32'h41);
    check_eq("uart_stlen",  32'(arb_to_mc_len), 32'd1);
    mc_reply(32'h1234);
    check_eq("uart_strdata", arb_to_lsb_rdata, 32'd0);
    lsb_to_arb_req = 0;
    tick();

    // Flush during a fetch: reply is drained but never reported.
    if_to_arb_req = 1; if_to_arb_addr = 32'h300;
    wait_grant("flush");
    tick();
    clr_in = 1; if_to_arb_req = 0;
    tick();
    clr_in = 0;
    mc_reply(32'hDEADBEEF);
    check_eq("flush_nodone", 32'(arb_to_if_done), 32'd0);
    tick();
    check_eq("flush_idle",   32'(arb_to_mc_valid), 32'd0);

    // Byte load, response stretched by rdy_in low.
    set_lsb(1'b0, 3'd1, 32'h500, 32'd0);
    wait_grant("byte");
    mc_reply(32'h0000_00A5);
    check_eq("byte_done", 32'(arb_to_lsb_done), 32'd1);
    check_eq("byte_data", arb_to_lsb_rdata, 32'h0000_00A5);
    rdy_in = 0; lsb_to_arb_req = 0;
    tick(); tick();
    check_eq("byte_stretch", 32'(arb_to_lsb_done), 32'd1);
    rdy_in = 1;
    tick();
    check_eq("byte_end", 32'(arb_to_lsb_done), 32'd0);

    // Reset in the middle of an LSB transaction.
    set_lsb(1'b0, 3'd4, 32'h600, 32'd0);
    wait_grant("rstmid");
    tick();
    rst_in = 1;
    tick();
    check_eq("rstmid_valid", 32'(arb_to_mc_valid), 32'd0);
    check_eq("rstmid_addr",  arb_to_mc_addr, 32'd0);
    check_eq("rstmid_len",   32'(arb_to_mc_len), 32'd0);
    check_eq("rstmid_done",  32'(arb_to_lsb_done), 32'd0);
    rst_in = 0;
    wait_grant("rstmid_again");
    check_eq("rstmid_addr2", arb_to_mc_addr, 32'h600);
    mc_reply(32'h77);
    lsb_to_arb_req = 0;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if (if_to_arb_req && arb_to_if_done) if_to_arb_req = 0;
      else if (!if_to_arb_req && !arb_to_if_done && $urandom_range(0, 2) == 0) begin
        if_to_arb_req = 1; if_to_arb_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (lsb_to_arb_req && arb_to_lsb_done) lsb_to_arb_req = 0;
      else if (!lsb_to_arb_req && !arb_to_lsb_done && $urandom_range(0, 2) == 0) begin
        d = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 32'h30004 : 32'h30000)
                                        : $urandom;
        case ($urandom_range(0, 2))
          0:       set_lsb(1'($urandom_range(0, 1)), 3'd1, d, $urandom);
          1:       set_lsb(1'($urandom_range(0, 1)), 3'd2, d, $urandom);
          default: set_lsb(1'($urandom_range(0, 1)), 3'd4, d, $urandom);
        endcase
      end
      io_buffer_full = ($urandom_range(0, 3) == 0);
      rdy_in = ($urandom_range(0, 7) != 0);
      clr_in = if_to_arb_req && ($urandom_range(0, 15) == 0);
      if (clr_in) if_to_arb_req = 0;
      rst_in = ($urandom_range(0, 299) == 0);
      mc_to_arb_rdata = $urandom;
      mc_to_arb_done = arb_to_mc_valid ? ($urandom_range(0, 2) == 0)
                                       : ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
